clk_div_prog: RTL and testbench

- Programmable integer clock divider: the configurable successor to the fixed divide-by-2 clock_divider.
- Produces a registered divided clock clk_out, a one-cycle clk_en strobe per output period, and a safe ratio-change handshake.
- Ratio changes take effect only at output period boundaries; start and stop never produce a truncated high phase.
- Sits between the DIMC control/CSR logic, which supplies ratios, and the slow-domain macro logic, which consumes clk_out or clk_en.

---
 rtl/clk_div_pkg.sv | 25 ++
 rtl/clk_div_phase_cnt.sv | 64 ++++++
 rtl/clk_div_prog.sv | 118 +++++++++++
 tb/tb_clk_div_prog.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the programmable clock divider.
//   - div_state_e : divider FSM state (IDLE, RUN, PEND)
//   - CNT_W       : default width of the ratio and period counter
//   - DEFAULT_DIV : default ratio loaded at reset
//   - MIN_DIV     : smallest legal divide ratio
//   - high_len()  : length of the clk_out high phase for a given ratio
package clk_div_pkg;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned DEFAULT_DIV = 2;
    localparam int unsigned MIN_DIV     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } div_state_e;

    // High phase is ceil(N/2), so odd ratios get the extra cycle in the high phase.
    // Computed at 32 bits so N = 2^CNT_W - 1 cannot overflow.
    function automatic int unsigned high_len(input int unsigned n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_phase_cnt.sv
// clk_div_phase_cnt: period counter and divided-clock generation.
//   clk      in   source clock
//   rst      in   asynchronous active-high reset
//   run      in   divider is running in the next cycle
//   ratio    in   divide ratio N in use (only changes while cnt wraps to 0)
//   clk_out  out  registered divided clock, equals (cnt < ceil(N/2))
//   clk_en   out  registered strobe, high in cycles where cnt == 0 while running
//   last_cyc out  current cycle is the final cycle of a period (cnt == N-1)
module clk_div_phase_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] ratio,
    output logic             clk_out,
    output logic             clk_en,
    output logic             last_cyc
);
    import clk_div_pkg::*;

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clk_out_q;
    logic             clk_en_q;
    logic             clk_out_d;
    logic             clk_en_d;

    assign last_cyc = active_q && (cnt_q == (ratio - CNT_W'(1)));

    // A fresh start (from idle) or a period wrap both restart at 0; the high phase
    // is evaluated on the next count so clk_out always matches its own cycle's cnt.
    always_comb begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        clk_en_d  = 1'b0;
        if (run) begin
            if (active_q && !last_cyc) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            clk_out_d = 32'(cnt_d) < high_len(32'(ratio));
            clk_en_d  = (cnt_d == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            active_q  <= run;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            clk_en_q  <= clk_en_d;
        end
    end

    assign clk_out = clk_out_q;
    assign clk_en  = clk_en_q;

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable integer clock divider with a safe ratio-change handshake.
//   clk        in   source clock
//   rst        in   asynchronous active-high reset
//   enable     in   run request for the divided clock
//   div_valid  in   new ratio offered
//   div_ratio  in   requested divide ratio N
//   div_ready  out  ratio can be accepted this cycle (only combinational output)
//   div_done   out  one-cycle pulse: accepted ratio now active
//   div_err    out  one-cycle pulse: illegal ratio (N < 2) rejected
//   clk_out    out  registered divided clock
//   clk_en     out  one-cycle pulse at the start of each clk_out period
//   busy       out  divider running (RUN or PEND)
//   cur_ratio  out  ratio currently in use
module clk_div_prog #(
    parameter int unsigned CNT_W       = clk_div_pkg::CNT_W,
    parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             div_valid,
    input  logic [CNT_W-1:0] div_ratio,
    output logic             div_ready,
    output logic             div_done,
    output logic             div_err,
    output logic             clk_out,
    output logic             clk_en,
    output logic             busy,
    output logic [CNT_W-1:0] cur_ratio
);
    import clk_div_pkg::*;

    div_state_e       state_q;
    logic [CNT_W-1:0] cur_q;
    logic [CNT_W-1:0] pend_q;
    logic             done_q;
    logic             err_q;
    logic             busy_q;

    logic             accept;
    logic             legal;
    logic             last_cyc;
    logic             run_next;

    assign div_ready = (state_q != PEND);
    assign accept    = div_valid && div_ready;
    assign legal     = 32'(div_ratio) >= MIN_DIV;

    // Stop/continue is only decided at a period boundary (or while idle), so a
    // dropped enable always lets the current period finish.
    assign run_next = ((state_q == IDLE) || last_cyc) ? enable : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= CNT_W'(DEFAULT_DIV);
            pend_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= accept && !legal;
            busy_q <= run_next;
            unique case (state_q)
                IDLE: begin
                    if (accept && legal) begin
                        cur_q  <= div_ratio;
                        done_q <= 1'b1;
                    end
                    if (enable) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (last_cyc) begin
                        // Accept on the boundary cycle applies directly, no PEND stay.
                        if (accept && legal) begin
                            cur_q  <= div_ratio;
                            done_q <= 1'b1;
                        end
                        state_q <= enable ? RUN : IDLE;
                    end else if (accept && legal) begin
                        pend_q  <= div_ratio;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (last_cyc) begin
                        cur_q   <= pend_q;
                        pend_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= enable ? RUN : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    clk_div_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .run      (run_next),
        .ratio    (cur_q),
        .clk_out  (clk_out),
        .clk_en   (clk_en),
        .last_cyc (last_cyc)
    );

    assign div_done  = done_q;
    assign div_err   = err_q;
    assign busy      = busy_q;
    assign cur_ratio = cur_q;

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       div_valid;
    logic [7:0] div_ratio;
    logic       div_ready;
    logic       div_done;
    logic       div_err;
    logic       clk_out;
    logic       clk_en;
    logic       busy;
    logic [7:0] cur_ratio;

    int n_vec = 0;
    int n_err = 0;

    clk_div_prog dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .div_valid (div_valid),
        .div_ratio (div_ratio),
        .div_ready (div_ready),
        .div_done  (div_done),
        .div_err   (div_err),
        .clk_out   (clk_out),
        .clk_en    (clk_en),
        .busy      (busy),
        .cur_ratio (cur_ratio)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position within the current period, the ratio in use,
    // and at most one waiting ratio.
    bit m_run;
    int m_pos;
    int m_n;
    bit m_has_pend;
    int m_pend;
    bit m_done;
    bit m_err;

    always @(posedge clk or posedge rst) begin : model_step
        bit acc;
        bit ok;
        if (rst) begin
            m_run      = 1'b0;
            m_pos      = 0;
            m_n        = 2;
            m_has_pend = 1'b0;
            m_pend     = 0;
            m_done     = 1'b0;
            m_err      = 1'b0;
        end else begin
            acc    = div_valid && !m_has_pend;
            ok     = int'(div_ratio) >= 2;
            m_done = 1'b0;
            m_err  = acc && !ok;
            if (!m_run) begin
                if (acc && ok) begin
                    m_n    = int'(div_ratio);
                    m_done = 1'b1;
                end
                m_run = enable;
                m_pos = 0;
            end else if (m_pos == m_n - 1) begin
                if (m_has_pend) begin
                    m_n        = m_pend;
                    m_has_pend = 1'b0;
                    m_done     = 1'b1;
                end else if (acc && ok) begin
                    m_n    = int'(div_ratio);
                    m_done = 1'b1;
                end
                m_pos = 0;
                m_run = enable;
            end else begin
                if (acc && ok) begin
                    m_pend     = int'(div_ratio);
                    m_has_pend = 1'b1;
                end
                m_pos = m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("clk_out", int'(clk_out), int'(m_run && (m_pos < (m_n + 1) / 2)));
            check("clk_en", int'(clk_en), int'(m_run && (m_pos == 0)));
            check("busy", int'(busy), int'(m_run));
            check("div_ready", int'(div_ready), int'(!m_has_pend));
            check("div_done", int'(div_done), int'(m_done));
            check("div_err", int'(div_err), int'(m_err));
            check("cur_ratio", int'(cur_ratio), m_n);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] pat5;
    logic [9:0] en5;
    logic [5:0] pat6;
    int         hi_pct;

    initial begin
        pat5      = 10'b1110011100;
        en5       = 10'b1000010000;
        pat6      = 6'b111000;
        rst       = 1'b0;
        enable    = 1'b0;
        div_valid = 1'b0;
        div_ratio = 8'd0;
        #1 rst = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_cur_ratio", int'(cur_ratio), 2);
        check("rst_ready", int'(div_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_clk_en", int'(clk_en), 0);

        // Divide by 2 from reset
        rst    = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("div2_clk_out", int'(clk_out), (i % 2 == 0) ? 1 : 0);
            check("div2_clk_en", int'(clk_en), (i % 2 == 0) ? 1 : 0);
            check("div2_busy", int'(busy), 1);
        end
        enable = 1'b0;
        tick();
        check("div2_stop_clk_out", int'(clk_out), 0);
        check("div2_stop_busy", int'(busy), 0);

        // Ratio 5 written while idle
        div_valid = 1'b1;
        div_ratio = 8'd5;
        tick();
        div_valid = 1'b0;
        check("idle_wr_done", int'(div_done), 1);
        check("idle_wr_cur", int'(cur_ratio), 5);
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("div5_clk_out", int'(clk_out), int'(pat5[9-i]));
            check("div5_clk_en", int'(clk_en), int'(en5[9-i]));
        end

        // Accept on the boundary cycle: applied directly
        div_valid = 1'b1;
        div_ratio = 8'd4;
        tick();
        div_valid = 1'b0;
        check("bnd_done", int'(div_done), 1);
        check("bnd_cur", int'(cur_ratio), 4);
        check("bnd_clk_en", int'(clk_en), 1);

        // Running N=4, write N=6 at cnt=1
        tick();
        div_valid = 1'b1;
        div_ratio = 8'd6;
        check("n4_ready_before", int'(div_ready), 1);
        tick();
        div_valid = 1'b0;
        check("pend_ready_c2", int'(div_ready), 0);
        check("pend_clk_out_c2", int'(clk_out), 0);
        check("pend_cur_c2", int'(cur_ratio), 4);
        tick();
        check("pend_ready_c3", int'(div_ready), 0);
        check("pend_done_c3", int'(div_done), 0);
        tick();
        check("n6_done", int'(div_done), 1);
        check("n6_cur", int'(cur_ratio), 6);
        check("n6_ready", int'(div_ready), 1);
        check("n6_clk_en", int'(clk_en), 1);
        check("n6_clk_out_0", int'(clk_out), 1);
        for (int i = 1; i < 6; i++) begin
            tick();
            check("n6_clk_out", int'(clk_out), int'(pat6[5-i]));
        end

        // Switch to N=3, then offer illegal ratios 1 and 0
        div_valid = 1'b1;
        div_ratio = 8'd3;
        tick();
        check("n3_done", int'(div_done), 1);
        div_ratio = 8'd1;
        tick();
        check("err1", int'(div_err), 1);
        check("err1_cur", int'(cur_ratio), 3);
        check("err1_clk_out", int'(clk_out), 1);
        div_ratio = 8'd0;
        tick();
        check("err0", int'(div_err), 1);
        check("err0_done", int'(div_done), 0);
        check("err0_clk_out", int'(clk_out), 0);
        div_valid = 1'b0;
        tick();
        check("err_clear", int'(div_err), 0);
        check("err_after_clk_en", int'(clk_en), 1);
        check("err_after_cur", int'(cur_ratio), 3);

        // Move to N=4, then drop enable at cnt=1
        div_valid = 1'b1;
        div_ratio = 8'd4;
        tick();
        div_valid = 1'b0;
        tick();
        tick();
        check("n4b_done", int'(div_done), 1);
        tick();
        enable = 1'b0;
        tick();
        check("stop_c2_clk_out", int'(clk_out), 0);
        check("stop_c2_busy", int'(busy), 1);
        tick();
        check("stop_c3_busy", int'(busy), 1);
        tick();
        check("stop_idle_clk_out", int'(clk_out), 0);
        check("stop_idle_busy", int'(busy), 0);
        check("stop_idle_clk_en", int'(clk_en), 0);

        // Async reset mid-period with N=7 at cnt=2
        div_valid = 1'b1;
        div_ratio = 8'd7;
        enable    = 1'b1;
        tick();
        div_valid = 1'b0;
        check("n7_done", int'(div_done), 1);
        check("n7_clk_out", int'(clk_out), 1);
        tick();
        tick();
        check("n7_c2_clk_out", int'(clk_out), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_clk_out", int'(clk_out), 0);
        check("arst_cur", int'(cur_ratio), 2);
        check("arst_busy", int'(busy), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_clk_out", int'(clk_out), (i % 2 == 0) ? 1 : 0);
        end

        // Randomized traffic, checked every cycle by the model
        hi_pct = 90;
        for (int c = 0; c < 3000; c++) begin
            int r;
            tick();
            if (c % 64 == 0) hi_pct = ($urandom_range(0, 1) == 0) ? 90 : 30;
            enable    = ($urandom_range(0, 99) < hi_pct);
            div_valid = ($urandom_range(0, 5) == 0);
            r         = $urandom_range(0, 19);
            if (r < 2)       div_ratio = 8'(r);
            else if (r < 18) div_ratio = 8'(2 + $urandom_range(0, 7));
            else if (r == 18) div_ratio = 8'd255;
            else             div_ratio = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
